// File: rtl/axi_stream_remove_header.sv
// Strips an N-byte header (N given per packet on the hlen channel) from an AXI-Stream packet and realigns the payload.
// Build option: define AXIS_RH_RUNT_ERR_EN to add err_runt and drop runt packets instead of emitting a header.
//
// state | meaning
// IDLE  | waiting for the header length of the next packet
// HDR   | waiting for the first beat; splits it into header and residual
// BODY  | merging residual with the head of each following beat
// FLUSH | emitting the bytes left over after the last beat
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic [DATA_WD-1:0]            data_in,
  input  logic [DATA_BYTE_WD-1:0]       keep_in,
  input  logic                          last_in,
  input  logic                          valid_hlen,
  output logic                          ready_hlen,
  input  logic [$clog2(DATA_BYTE_WD):0] hlen,
  output logic                          valid_hdr,
  input  logic                          ready_hdr,
  output logic [DATA_WD-1:0]            header_out,
  output logic [DATA_BYTE_WD-1:0]       keep_hdr,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [DATA_WD-1:0]            data_out,
  output logic [DATA_BYTE_WD-1:0]       keep_out,
  output logic                          last_out
`ifdef AXIS_RH_RUNT_ERR_EN
  ,
  output logic                          err_runt
`endif
);

  localparam int HW = $clog2(DATA_BYTE_WD) + 1;
  localparam int CW = HW + 1;
  localparam logic [HW-1:0] BYTES_H = HW'(DATA_BYTE_WD);
  localparam logic [CW-1:0] BYTES_C = CW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [HW-1:0]             r_n;
  logic [DATA_WD-1:0]        r_resid;
  logic [CW-1:0]             r_flush_cnt;
  logic                      r_ready_hlen;
  logic                      r_valid_out;
  logic [DATA_WD-1:0]        r_data_out;
  logic [DATA_BYTE_WD-1:0]   r_keep_out;
  logic                      r_last_out;
  logic                      r_valid_hdr;
  logic [DATA_WD-1:0]        r_header;
  logic [DATA_BYTE_WD-1:0]   r_keep_hdr;

  logic                      w_out_free;
  logic                      w_hdr_free;
  logic                      w_ready_in;
  logic                      w_acc;
  logic                      w_hlen_acc;
  logic [HW-1:0]             w_hlen_clamp;
  logic [CW-1:0]             w_cnt;
  logic [CW-1:0]             w_n_c;
  logic [CW-1:0]             w_pending;
  logic [CW-1:0]             w_tail;
  logic [HW-1:0]             w_hdr_shamt;
  logic [DATA_WD-1:0]        w_hdr_data;
  logic [DATA_WD-1:0]        w_hi;
  logic [DATA_WD-1:0]        w_lo;
  logic [2*DATA_WD-1:0]      w_cat;
  logic [DATA_WD-1:0]        w_shift;
  logic [DATA_WD-1:0]        w_out_data;
  logic [DATA_BYTE_WD-1:0]   w_out_keep;
  logic                      w_out_last;
  logic                      w_ld_out;
  logic                      w_ld_hdr;
  logic                      w_ld_flush;
`ifdef AXIS_RH_RUNT_ERR_EN
  logic                      w_runt;
  logic                      r_err_runt;
`endif

  function automatic logic [DATA_BYTE_WD-1:0] f_keep_top(input logic [CW-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] ones;
    ones = '1;
    return ~(ones >> cnt);
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] f_keep_low(input logic [HW-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] ones;
    ones = '1;
    return ~(ones << cnt);
  endfunction

  function automatic logic [CW-1:0] f_popcnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) s = s + CW'(k[i]);
    return s;
  endfunction

  function automatic logic [DATA_WD-1:0] f_byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  assign w_out_free   = !r_valid_out || ready_out;
  assign w_hdr_free   = !r_valid_hdr || ready_hdr;
  assign w_ready_in   = ((r_state == HDR) && w_out_free && w_hdr_free) ||
                        ((r_state == BODY) && w_out_free);
  assign w_acc        = valid_in && w_ready_in;
  assign w_hlen_acc   = (r_state == IDLE) && valid_hlen && r_ready_hlen;
  assign w_hlen_clamp = (hlen > BYTES_H) ? BYTES_H : hlen;

  assign w_cnt       = f_popcnt(keep_in);
  assign w_n_c       = {1'b0, r_n};
  assign w_pending   = BYTES_C - w_n_c + w_cnt;
  assign w_tail      = w_cnt - w_n_c;
  assign w_hdr_shamt = BYTES_H - r_n;
  assign w_hdr_data  = data_in >> {w_hdr_shamt, 3'b000};

  // One shifter serves all cases: the upper half of {hi, lo} << 8N is {hi minus its top N bytes, top N bytes of lo}.
  assign w_hi       = (r_state == HDR) ? data_in : r_resid;
  assign w_lo       = (r_state == FLUSH) ? '0 : data_in;
  assign w_cat      = {w_hi, w_lo} << {r_n, 3'b000};
  assign w_shift    = w_cat[2*DATA_WD-1 -: DATA_WD];
  assign w_out_data = w_shift & f_byte_mask(w_out_keep);

  always_comb begin
    w_state_nxt = r_state;
    w_ld_out    = 1'b0;
    w_out_keep  = '0;
    w_out_last  = 1'b0;
    w_ld_hdr    = 1'b0;
    w_ld_flush  = 1'b0;
`ifdef AXIS_RH_RUNT_ERR_EN
    w_runt      = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_hlen_acc) w_state_nxt = HDR;
      end
      HDR: begin
        if (w_acc) begin
          if (last_in) begin
            w_state_nxt = IDLE;
`ifdef AXIS_RH_RUNT_ERR_EN
            if (w_cnt < w_n_c) w_runt = 1'b1;
            else
`endif
            begin
              w_ld_hdr = (r_n != '0);
              if (w_cnt > w_n_c) begin
                w_ld_out   = 1'b1;
                w_out_keep = f_keep_top(w_tail);
                w_out_last = 1'b1;
              end
            end
          end else begin
            w_ld_hdr    = (r_n != '0);
            w_state_nxt = BODY;
          end
        end
      end
      BODY: begin
        if (w_acc) begin
          w_ld_out = 1'b1;
          if (!last_in) begin
            w_out_keep = '1;
          end else if (w_pending <= BYTES_C) begin
            w_out_keep  = f_keep_top(w_pending);
            w_out_last  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_out_keep  = '1;
            w_ld_flush  = 1'b1;
            w_state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (w_out_free) begin
          w_ld_out    = 1'b1;
          w_out_keep  = f_keep_top(r_flush_cnt);
          w_out_last  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n          <= '0;
      r_resid      <= '0;
      r_flush_cnt  <= '0;
      r_ready_hlen <= 1'b0;
      r_valid_out  <= 1'b0;
      r_data_out   <= '0;
      r_keep_out   <= '0;
      r_last_out   <= 1'b0;
      r_valid_hdr  <= 1'b0;
      r_header     <= '0;
      r_keep_hdr   <= '0;
    end else begin
      r_ready_hlen <= (w_state_nxt == IDLE);
      if (w_hlen_acc) r_n <= w_hlen_clamp;
      if (w_acc) r_resid <= data_in;
      if (w_ld_flush) r_flush_cnt <= w_tail;
      if (w_ld_out) begin
        r_valid_out <= 1'b1;
        r_data_out  <= w_out_data;
        r_keep_out  <= w_out_keep;
        r_last_out  <= w_out_last;
      end else if (ready_out) begin
        r_valid_out <= 1'b0;
      end
      if (w_ld_hdr) begin
        r_valid_hdr <= 1'b1;
        r_header    <= w_hdr_data;
        r_keep_hdr  <= f_keep_low(r_n);
      end else if (ready_hdr) begin
        r_valid_hdr <= 1'b0;
      end
    end
  end

`ifdef AXIS_RH_RUNT_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_runt <= 1'b0;
    else        r_err_runt <= w_runt;
  end

  assign err_runt = r_err_runt;
`endif

  assign ready_in   = w_ready_in;
  assign ready_hlen = r_ready_hlen;
  assign valid_out  = r_valid_out;
  assign data_out   = r_data_out;
  assign keep_out   = r_keep_out;
  assign last_out   = r_last_out;
  assign valid_hdr  = r_valid_hdr;
  assign header_out = r_header;
  assign keep_hdr   = r_keep_hdr;

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Scoreboard bench for axi_stream_remove_header (DATA_WD=32): a byte-level model queues expected header and payload beats.
module tb_axi_stream_remove_header;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        valid_hlen = 1'b0;
  logic        ready_hlen;
  logic [2:0]  hlen = '0;
  logic        valid_hdr;
  logic        ready_hdr = 1'b1;
  logic [31:0] header_out;
  logic [3:0]  keep_hdr;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
`ifdef AXIS_RH_RUNT_ERR_EN
  logic        err_runt;
`endif

  axi_stream_remove_header #(.DATA_WD(32), .DATA_BYTE_WD(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .valid_hlen(valid_hlen), .ready_hlen(ready_hlen), .hlen(hlen),
    .valid_hdr(valid_hdr), .ready_hdr(ready_hdr), .header_out(header_out), .keep_hdr(keep_hdr),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out)
`ifdef AXIS_RH_RUNT_ERR_EN
    , .err_runt(err_runt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } pay_t;
  typedef struct packed { logic [31:0] d; logic [3:0] k; logic chk; } hdr_t;

  pay_t        exp_pay[$];
  hdr_t        exp_hdr[$];
  int          exp_runt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pk_d[16];
  logic [3:0]  pk_k[16];

  // Byte-level model: concatenate valid bytes, drop the first N, repack MSB-first into 4-byte beats.
  task automatic push_expect(input int n_raw, input int nb);
    int         n, c0, idx;
    logic [7:0] bq[$];
    pay_t       p;
    hdr_t       h;
    bit         runt;
    n  = (n_raw > 4) ? 4 : n_raw;
    c0 = 0;
    for (int i = 0; i < 4; i++) if (pk_k[0][3-i]) c0++;
    runt = (nb == 1) && (c0 < n);
`ifdef AXIS_RH_RUNT_ERR_EN
    if (runt) begin
      exp_runt++;
      return;
    end
`endif
    if (n > 0) begin
      h.d = '0;
      for (int i = 0; i < n; i++) h.d = {h.d[23:0], pk_d[0][31-8*i -: 8]};
      h.k   = 4'((1 << n) - 1);
      h.chk = !runt;
      exp_hdr.push_back(h);
    end
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < 4; i++)
        if (pk_k[b][3-i]) bq.push_back(pk_d[b][31-8*i -: 8]);
    idx = n;
    while (idx < bq.size()) begin
      p = '0;
      for (int j = 0; j < 4; j++) begin
        if (idx < bq.size()) begin
          p.d[31-8*j -: 8] = bq[idx];
          p.k[3-j] = 1'b1;
          idx++;
        end
      end
      p.l = (idx >= bq.size());
      exp_pay.push_back(p);
    end
  endtask

  pay_t        mon_p;
  hdr_t        mon_h;
  logic        po_hold = 1'b0, ph_hold = 1'b0;
  logic [31:0] po_d, ph_d;
  logic [3:0]  po_k, ph_k;
  logic        po_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      po_hold = 1'b0;
    end else begin
      if (po_hold) begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== po_d || keep_out !== po_k || last_out !== po_l) begin
          errors++;
          $display("FAIL out_hold valid=%b data=%h keep=%h last=%b required valid=1 data=%h keep=%h last=%b",
                   valid_out, data_out, keep_out, last_out, po_d, po_k, po_l);
        end
      end
      if (valid_out && ready_out) begin
        checks++;
        if (exp_pay.size() == 0) begin
          errors++;
          $display("FAIL out_extra data=%h keep=%h last=%b required no beat", data_out, keep_out, last_out);
        end else begin
          mon_p = exp_pay.pop_front();
          if (data_out !== mon_p.d || keep_out !== mon_p.k || last_out !== mon_p.l) begin
            errors++;
            $display("FAIL out_beat data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                     data_out, keep_out, last_out, mon_p.d, mon_p.k, mon_p.l);
          end
        end
      end
      po_hold = valid_out && !ready_out;
      po_d = data_out; po_k = keep_out; po_l = last_out;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      ph_hold = 1'b0;
    end else begin
      if (ph_hold) begin
        checks++;
        if (valid_hdr !== 1'b1 || header_out !== ph_d || keep_hdr !== ph_k) begin
          errors++;
          $display("FAIL hdr_hold valid=%b hdr=%h keep=%h required valid=1 hdr=%h keep=%h",
                   valid_hdr, header_out, keep_hdr, ph_d, ph_k);
        end
      end
      if (valid_hdr && ready_hdr) begin
        checks++;
        if (exp_hdr.size() == 0) begin
          errors++;
          $display("FAIL hdr_extra hdr=%h keep=%h required no header", header_out, keep_hdr);
        end else begin
          mon_h = exp_hdr.pop_front();
          if (keep_hdr !== mon_h.k || (mon_h.chk && header_out !== mon_h.d)) begin
            errors++;
            $display("FAIL hdr_beat hdr=%h keep=%h required hdr=%h keep=%h",
                     header_out, keep_hdr, mon_h.d, mon_h.k);
          end
        end
      end
      ph_hold = valid_hdr && !ready_hdr;
      ph_d = header_out; ph_k = keep_hdr;
    end
  end

`ifdef AXIS_RH_RUNT_ERR_EN
  always @(negedge clk) begin
    if (rst_n && err_runt) begin
      checks++;
      if (exp_runt == 0) begin
        errors++;
        $display("FAIL runt_pulse err_runt=1 required 0");
      end else begin
        exp_runt--;
      end
    end
  end
`endif

  task automatic drive_hlen(input int n);
    int t;
    valid_hlen = 1'b1;
    hlen = 3'(n);
    t = 0;
    @(negedge clk);
    while (!ready_hlen && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready_hlen) begin
      checks++; errors++;
      $display("FAIL hlen_timeout ready_hlen=0 required 1");
    end
    @(posedge clk); #1;
    valid_hlen = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    t = 0;
    @(negedge clk);
    while (!ready_in && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready_in) begin
      checks++; errors++;
      $display("FAIL beat_timeout ready_in=0 required 1");
    end
    @(posedge clk); #1;
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic send_packet(input int n, input int nb, input bit gaps);
    push_expect(n, nb);
    drive_hlen(n);
    for (int b = 0; b < nb; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive_beat(pk_d[b], pk_k[b], b == nb - 1);
    end
  endtask

  task automatic wait_drain(output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0 || !ready_hlen) && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    ok = (exp_pay.size() == 0) && (exp_hdr.size() == 0);
    @(posedge clk); #1;
  endtask

  task automatic load_abc();
    pk_d[0] = 32'hA1A2A3A4; pk_k[0] = 4'hF;
    pk_d[1] = 32'hB1B2B3B4; pk_k[1] = 4'hF;
    pk_d[2] = 32'hC1C2C3C4; pk_k[2] = 4'hC;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({valid_out, valid_hdr, last_out} !== 3'b000) begin
      errors++;
      $display("FAIL rst_valid valid_out=%b valid_hdr=%b last_out=%b required 000", valid_out, valid_hdr, last_out);
    end
    checks++;
    if ({ready_in, ready_hlen} !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready ready_in=%b ready_hlen=%b required 00", ready_in, ready_hlen);
    end
    checks++;
    if (data_out !== 32'h0 || keep_out !== 4'h0 || header_out !== 32'h0 || keep_hdr !== 4'h0) begin
      errors++;
      $display("FAIL rst_data data=%h keep=%h hdr=%h keep_hdr=%h required all 0", data_out, keep_out, header_out, keep_hdr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_hlen !== 1'b1 || ready_in !== 1'b0) begin
      errors++;
      $display("FAIL rst_release ready_hlen=%b ready_in=%b required 1 0", ready_hlen, ready_in);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    load_abc();
    send_packet(2, 3, 0);
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_drain pending pay=%0d hdr=%0d required 0 0", exp_pay.size(), exp_hdr.size());
    end
  endtask

  task automatic test_flush();
    bit ok;
    load_abc();
    send_packet(1, 3, 0);
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL flush_drain pending pay=%0d hdr=%0d required 0 0", exp_pay.size(), exp_hdr.size());
    end
  endtask

  task automatic test_n0_backpressure();
    bit          ok;
    logic [31:0] d0;
    int          t;
    for (int b = 0; b < 5; b++) begin
      pk_d[b] = 32'h10203040 + 32'h01010101 * b;
      pk_k[b] = 4'hF;
    end
    pk_k[4] = 4'hE;
    fork
      send_packet(0, 5, 0);
      begin
        t = 0;
        @(negedge clk);
        while (!valid_out && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        ready_out = 1'b0;
        @(negedge clk);
        d0 = data_out;
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          checks++;
          if (valid_out !== 1'b1 || data_out !== d0 || ready_in !== 1'b0 || valid_hdr !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall valid_out=%b data=%h ready_in=%b valid_hdr=%b required 1 %h 0 0",
                     valid_out, data_out, ready_in, valid_hdr, d0);
          end
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
      end
    join
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_drain pending pay=%0d hdr=%0d required 0 0", exp_pay.size(), exp_hdr.size());
    end
  endtask

  task automatic test_hdr_only();
    bit ok;
    pk_d[0] = 32'hA1A2A3A4; pk_k[0] = 4'hF;
    send_packet(4, 1, 0);
    pk_d[0] = 32'hD1D2D3D4; pk_k[0] = 4'hF;
    pk_d[1] = 32'hE1E2E3E4; pk_k[1] = 4'hE;
    send_packet(7, 2, 0);
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hdr_only_drain pending pay=%0d hdr=%0d required 0 0", exp_pay.size(), exp_hdr.size());
    end
  endtask

  task automatic test_runt();
    bit ok;
    pk_d[0] = 32'h5A6B7C8D; pk_k[0] = 4'hC;
    send_packet(4, 1, 0);
    wait_drain(ok);
    checks++;
    if (!ok || exp_runt != 0) begin
      errors++;
      $display("FAIL runt_drain pending pay=%0d hdr=%0d runt=%0d required 0 0 0", exp_pay.size(), exp_hdr.size(), exp_runt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ready_out = 1'b0; ready_hdr = 1'b0;
    drive_hlen(2);
    drive_beat(32'hA1A2A3A4, 4'hF, 1'b0);
    drive_beat(32'hB1B2B3B4, 4'hF, 1'b0);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || valid_hdr !== 1'b1) begin
      errors++;
      $display("FAIL mid_inflight valid_out=%b valid_hdr=%b required 1 1", valid_out, valid_hdr);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid_out, valid_hdr, last_out, ready_in, ready_hlen} !== 5'b0 || data_out !== 32'h0 || keep_out !== 4'h0 ||
        header_out !== 32'h0 || keep_hdr !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset vo=%b vh=%b lo=%b ri=%b rh=%b data=%h keep=%h hdr=%h kh=%h required all 0",
               valid_out, valid_hdr, last_out, ready_in, ready_hlen, data_out, keep_out, header_out, keep_hdr);
    end
    ready_out = 1'b1; ready_hdr = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_abc();
    send_packet(2, 3, 0);
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_after_drain pending pay=%0d hdr=%0d required 0 0", exp_pay.size(), exp_hdr.size());
    end
  endtask

  task automatic test_back_to_back();
    bit         done, ok;
    int         n, nb, c;
    logic [3:0] lk;
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 24; p++) begin
          n  = $urandom_range(0, 7);
          nb = $urandom_range(1, 5);
          for (int b = 0; b < nb; b++) begin
            pk_d[b] = $urandom;
            pk_k[b] = 4'hF;
          end
          c  = $urandom_range(1, 4);
          lk = 4'hF << (4 - c);
          pk_k[nb-1] = lk;
          send_packet(n, nb, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ready_out = ($urandom_range(0, 3) != 0);
          ready_hdr = ($urandom_range(0, 2) != 0);
        end
        ready_out = 1'b1; ready_hdr = 1'b1;
      end
    join
    wait_drain(ok);
    checks++;
    if (!ok || exp_runt != 0) begin
      errors++;
      $display("FAIL b2b_drain pending pay=%0d hdr=%0d runt=%0d required 0 0 0", exp_pay.size(), exp_hdr.size(), exp_runt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_n0_backpressure();
    test_hdr_only();
    test_runt();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
